// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS datapath helpers, including the
// register-file spill engine state machine.
`timescale 1ns/1ps
package mips_pkg;

   localparam int NUM_GPR  = 32;
   localparam int LAST_GPR = NUM_GPR - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } spill_state_t;

   typedef enum logic {
      SPILL_SAVE    = 1'b0,
      SPILL_RESTORE = 1'b1
   } spill_mode_t;

endpackage

// File: rtl/regfile_spill_engine.sv
// Context save/restore engine driving the register file ports for GPRs $1..$31.
// Optional build macro REGFILE_SPILL_CHECKSUM_EN adds an XOR checksum output.
`timescale 1ns/1ps
module regfile_spill_engine
   import mips_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_GPR = mips_pkg::NUM_GPR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] beat_idx,
   output logic [ADDR_W-1:0] rf_ra,
   input  logic [DATA_W-1:0] rf_rd,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready
`ifdef REGFILE_SPILL_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_GPR - 1);

   spill_state_t      state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [ADDR_W-1:0] rf_ra_q, rf_ra_d;
   logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
   logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
   logic              save_fire_s;
   logic              restore_fire_s;
   logic              last_s;
   logic [DATA_W-1:0] beat_word_s;
   logic [DATA_W-1:0] checksum_q, checksum_d;

   assign save_fire_s    = out_valid_q & out_ready;
   assign restore_fire_s = in_ready_q & in_valid;
   assign last_s         = (idx_q == LAST_IDX);
   assign beat_word_s    = out_valid_q ? rf_rd : in_data;

   // Next state, index and registered control outputs derived from the upcoming state.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      checksum_d = checksum_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d      = ONE_IDX;
               checksum_d = '0;
               if (spill_mode_t'(mode) == SPILL_RESTORE) begin
                  state_d = RESTORE;
               end else begin
                  state_d = SAVE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         SAVE: begin
            if (save_fire_s) begin
               checksum_d = checksum_q ^ beat_word_s;
               if (last_s) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + ONE_IDX;
               end
            end else begin
               state_d = SAVE;
            end
         end
         RESTORE: begin
            if (restore_fire_s) begin
               checksum_d = checksum_q ^ beat_word_s;
               if (last_s) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + ONE_IDX;
               end
            end else begin
               state_d = RESTORE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d      = (state_d == SAVE) || (state_d == RESTORE);
      done_d      = (state_d == DONE);
      out_valid_d = (state_d == SAVE);
      in_ready_d  = (state_d == RESTORE);
      if (out_valid_d) begin
         rf_ra_d = idx_d;
      end else begin
         rf_ra_d = '0;
      end
      if (in_ready_d) begin
         rf_wa_d = idx_d;
      end else begin
         rf_wa_d = '0;
      end
      if (busy_d) begin
         beat_idx_d = idx_d - ONE_IDX;
      end else begin
         beat_idx_d = '0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         rf_ra_q     <= '0;
         rf_wa_q     <= '0;
         beat_idx_q  <= '0;
         checksum_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         rf_ra_q     <= rf_ra_d;
         rf_wa_q     <= rf_wa_d;
         beat_idx_q  <= beat_idx_d;
         checksum_q  <= checksum_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign beat_idx  = beat_idx_q;
   assign rf_ra     = rf_ra_q;
   assign rf_wa     = rf_wa_q;
   assign out_valid = out_valid_q;
   assign in_ready  = in_ready_q;
   assign out_data  = out_valid_q ? rf_rd : '0;
   // Reset must not let the abandoned beat land in the register file.
   assign rf_we     = in_ready_q & in_valid & ~reset;
   assign rf_wd     = in_ready_q ? in_data : '0;

`ifdef REGFILE_SPILL_CHECKSUM_EN
   assign checksum = checksum_q;
`else
   logic unused_checksum_s;
   assign unused_checksum_s = ^checksum_q;
`endif

endmodule
